register_bank_nw: RTL and testbench

REGISTER_BANK_NW -- requirements
Module: register_bank_nw

---
 rtl/regfile_pkg.sv | 18 +
 rtl/register_bank_nw_reg_entry.sv | 25 ++
 rtl/register_bank_nw.sv | 157 +++++++++++++++
 tb/tb_register_bank_nw.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and elaboration helpers for the register bank and its entries.
package regfile_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_ZERO_REG = 1;

  // Ceiling log2, used to size entry indices from the entry count.
  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v / 32'sd2) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/register_bank_nw_reg_entry.sv
// One storage entry of the register bank: WIDTH-bit register with load enable.
module reg_entry
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Entry storage: cleared asynchronously, captures d on a load cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/register_bank_nw.sv
// Register bank with per-entry pending (busy) tracking, write bypass to two
// combinational read ports and a sticky protocol-error flag.
module register_bank_nw
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = DEF_ZERO_REG,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_en,
  input  logic [AW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic [AW-1:0]    r0_addr,
  output logic [WIDTH-1:0] r0_data,
  output logic             r0_busy,
  input  logic [AW-1:0]    r1_addr,
  output logic [WIDTH-1:0] r1_data,
  output logic             r1_busy,
  output logic [DEPTH-1:0] busy,
  output logic             err
);

  localparam bit          HAS_ZERO = (ZERO_REG != 32'sd0);
  localparam bit          POW2     = ((32'sd1 << AW) == DEPTH);
  localparam logic [AW:0] DEPTH_L  = (AW + 1)'(DEPTH);

  logic             w_in_range_s;
  logic             rsv_in_range_s;
  logic             w_zero_s;
  logic             rsv_zero_s;
  logic             w_valid_s;
  logic             rsv_valid_s;
  logic             rsv_hit_busy_s;
  logic             err_set_s;
  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] busy_nxt_s;
  logic             err_r;
  logic [WIDTH-1:0] entry_s   [DEPTH];
  logic [AW-1:0]    rd_addr_s [2];
  logic [WIDTH-1:0] rd_data_s [2];
  logic             rd_busy_s [2];

  // With a power-of-2 depth every index is a real entry.
  generate
    if (POW2) begin : g_pow2
      assign w_in_range_s   = 1'b1;
      assign rsv_in_range_s = 1'b1;
    end else begin : g_npow2
      assign w_in_range_s   = ({1'b0, w_addr} < DEPTH_L);
      assign rsv_in_range_s = ({1'b0, rsv_addr} < DEPTH_L);
    end
  endgenerate

  assign w_zero_s    = HAS_ZERO && (w_addr == '0);
  assign rsv_zero_s  = HAS_ZERO && (rsv_addr == '0);
  assign w_valid_s   = w_en && w_in_range_s && !w_zero_s;
  assign rsv_valid_s = rsv_en && rsv_in_range_s && !rsv_zero_s;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      if (HAS_ZERO && (i == 0)) begin : g_zero
        assign entry_s[i] = '0;
      end else begin : g_reg
        logic load_s;
        assign load_s = w_valid_s && (w_addr == AW'(i));
        reg_entry #(.WIDTH(WIDTH)) u_entry (
          .clk  (clk),
          .rst  (rst),
          .load (load_s),
          .d    (w_data),
          .q    (entry_s[i])
        );
      end
    end
  endgenerate

  // Busy next-state: a write clears its entry, then a reserve sets its entry so it wins.
  always_comb begin
    busy_nxt_s     = busy_r;
    rsv_hit_busy_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid_s && (w_addr == AW'(i))) begin
        busy_nxt_s[i] = 1'b0;
      end else begin
        busy_nxt_s[i] = busy_nxt_s[i];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (rsv_valid_s && (rsv_addr == AW'(i))) begin
        busy_nxt_s[i]  = 1'b1;
        rsv_hit_busy_s = busy_r[i];
      end else begin
        busy_nxt_s[i]  = busy_nxt_s[i];
        rsv_hit_busy_s = rsv_hit_busy_s;
      end
    end
  end

  // Reserving a busy entry is only legal when the same cycle's write releases it.
  assign err_set_s = (w_en && !w_in_range_s)
                   || (rsv_en && !rsv_in_range_s)
                   || (rsv_hit_busy_s && !(w_valid_s && (w_addr == rsv_addr)));

  // Busy vector and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= '0;
      err_r  <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      err_r  <= err_r | err_set_s;
    end
  end

  assign rd_addr_s[0] = r0_addr;
  assign rd_addr_s[1] = r1_addr;

  // Read ports: stored value and busy flag, overridden by a same-cycle valid write.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_s[p] = '0;
      rd_busy_s[p] = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_addr_s[p] == AW'(i)) begin
          rd_data_s[p] = entry_s[i];
          rd_busy_s[p] = busy_r[i];
        end else begin
          rd_data_s[p] = rd_data_s[p];
          rd_busy_s[p] = rd_busy_s[p];
        end
      end
      if (rst) begin
        rd_data_s[p] = '0;
        rd_busy_s[p] = 1'b0;
      end else if (w_valid_s && (w_addr == rd_addr_s[p])) begin
        rd_data_s[p] = w_data;
        rd_busy_s[p] = 1'b0;
      end else begin
        rd_data_s[p] = rd_data_s[p];
        rd_busy_s[p] = rd_busy_s[p];
      end
    end
  end

  assign r0_data = rd_data_s[0];
  assign r0_busy = rd_busy_s[0];
  assign r1_data = rd_data_s[1];
  assign r1_busy = rd_busy_s[1];
  assign busy    = busy_r;
  assign err     = err_r;

endmodule

// File: tb/tb_register_bank_nw.sv
// Directed scoreboard bench for register_bank_nw: default 8-entry bank plus a 6-entry bank.
module tb_register_bank_nw;

  logic        clk;
  logic        rst, w_en, rsv_en, r0_busy, r1_busy, err;
  logic [2:0]  w_addr, rsv_addr, r0_addr, r1_addr;
  logic [15:0] w_data, r0_data, r1_data;
  logic [7:0]  busy;

  logic        b_rst, b_w_en, b_rsv_en, b_r0_busy, b_r1_busy, b_err;
  logic [2:0]  b_w_addr, b_rsv_addr, b_r0_addr, b_r1_addr;
  logic [15:0] b_w_data, b_r0_data, b_r1_data;
  logic [5:0]  b_busy;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  register_bank_nw dut_a (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .r0_addr(r0_addr), .r0_data(r0_data), .r0_busy(r0_busy),
    .r1_addr(r1_addr), .r1_data(r1_data), .r1_busy(r1_busy),
    .busy(busy), .err(err)
  );

  register_bank_nw #(.WIDTH(16), .DEPTH(6), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(b_rst), .w_en(b_w_en), .w_addr(b_w_addr), .w_data(b_w_data),
    .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
    .r0_addr(b_r0_addr), .r0_data(b_r0_data), .r0_busy(b_r0_busy),
    .r1_addr(b_r1_addr), .r1_data(b_r1_data), .r1_busy(b_r1_busy),
    .busy(b_busy), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [63:0] val);
    sb_q.push_back('{tag, val});
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    exp_t e;
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $error("FAIL sb_empty: observed %0h, no expected value queued", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        tests_failed++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; w_en = 1'b1; w_addr = 3'd3; w_data = 16'hAAAA;
    rsv_en = 1'b1; rsv_addr = 3'd5; r0_addr = 3'd3; r1_addr = 3'd5;
    b_rst = 1'b1; b_w_en = 1'b0; b_w_addr = 3'd0; b_w_data = 16'h0000;
    b_rsv_en = 1'b0; b_rsv_addr = 3'd0; b_r0_addr = 3'd0; b_r1_addr = 3'd0;

    // Held in reset with strobes active: everything reads zero.
    push("rst_r0_data", 64'h0); push("rst_r0_busy", 64'h0); push("rst_r1_busy", 64'h0);
    push("rst_busy", 64'h0); push("rst_err", 64'h0);
    @(negedge clk);
    pop_chk(64'(r0_data)); pop_chk(64'(r0_busy)); pop_chk(64'(r1_busy));
    pop_chk(64'(busy)); pop_chk(64'(err));

    next_cycle();
    rst = 1'b0; w_en = 1'b0; rsv_en = 1'b0;
    push("no_write_in_rst", 64'h0); push("no_rsv_in_rst", 64'h0);
    @(negedge clk);
    pop_chk(64'(r0_data)); pop_chk(64'(busy));

    // Write entry 3: bypass, then stored.
    next_cycle();
    w_en = 1'b1; w_addr = 3'd3; w_data = 16'h1234; r0_addr = 3'd3;
    push("wr3_bypass", 64'h1234);
    @(negedge clk);
    pop_chk(64'(r0_data));
    next_cycle();
    w_en = 1'b0;
    push("wr3_stored", 64'h1234); push("wr3_err", 64'h0);
    @(negedge clk);
    pop_chk(64'(r0_data)); pop_chk(64'(err));

    // Reserve entry 5, then release it with a write.
    next_cycle();
    rsv_en = 1'b1; rsv_addr = 3'd5; r1_addr = 3'd5;
    push("rsv5_pre_edge_r1_busy", 64'h0);
    @(negedge clk);
    pop_chk(64'(r1_busy));
    next_cycle();
    rsv_en = 1'b0;
    push("rsv5_busy", 64'h20); push("rsv5_r1_busy", 64'h1);
    @(negedge clk);
    pop_chk(64'(busy)); pop_chk(64'(r1_busy));
    next_cycle();
    w_en = 1'b1; w_addr = 3'd5; w_data = 16'hBEEF;
    push("wr5_r1_busy_masked", 64'h0); push("wr5_r1_bypass", 64'hBEEF); push("wr5_busy_pre_edge", 64'h20);
    @(negedge clk);
    pop_chk(64'(r1_busy)); pop_chk(64'(r1_data)); pop_chk(64'(busy));
    next_cycle();
    w_en = 1'b0;
    push("wr5_busy_clear", 64'h00); push("wr5_stored", 64'hBEEF); push("wr5_err", 64'h0);
    @(negedge clk);
    pop_chk(64'(busy)); pop_chk(64'(r1_data)); pop_chk(64'(err));

    // Same-cycle reserve and write of entry 4: data written, reserve wins.
    next_cycle();
    w_en = 1'b1; w_addr = 3'd4; w_data = 16'h00FF; rsv_en = 1'b1; rsv_addr = 3'd4; r0_addr = 3'd4;
    push("rw4_bypass", 64'h00FF);
    @(negedge clk);
    pop_chk(64'(r0_data));
    next_cycle();
    w_en = 1'b0; rsv_en = 1'b0;
    push("rw4_data", 64'h00FF); push("rw4_busy", 64'h10); push("rw4_r0_busy", 64'h1); push("rw4_err", 64'h0);
    @(negedge clk);
    pop_chk(64'(r0_data)); pop_chk(64'(busy)); pop_chk(64'(r0_busy)); pop_chk(64'(err));

    // Re-reserve busy entry 4 while writing it: legal, no error.
    next_cycle();
    w_en = 1'b1; w_data = 16'h0F0F; rsv_en = 1'b1;
    push("rw4b_r0_busy_masked", 64'h0);
    @(negedge clk);
    pop_chk(64'(r0_busy));
    next_cycle();
    w_en = 1'b0; rsv_en = 1'b0;
    push("rw4b_busy", 64'h10); push("rw4b_err", 64'h0); push("rw4b_data", 64'h0F0F);
    @(negedge clk);
    pop_chk(64'(busy)); pop_chk(64'(err)); pop_chk(64'(r0_data));

    // Entry 0 is hardwired zero: write and reserve ignored, no bypass.
    next_cycle();
    w_en = 1'b1; w_addr = 3'd0; w_data = 16'hFFFF; rsv_en = 1'b1; rsv_addr = 3'd0; r0_addr = 3'd0;
    push("z0_no_bypass", 64'h0);
    @(negedge clk);
    pop_chk(64'(r0_data));
    next_cycle();
    w_en = 1'b0; rsv_en = 1'b0;
    push("z0_data", 64'h0); push("z0_busy", 64'h10); push("z0_err", 64'h0);
    @(negedge clk);
    pop_chk(64'(r0_data)); pop_chk(64'(busy)); pop_chk(64'(err));

    // Both ports on one entry, bypassed and then stored.
    next_cycle();
    w_en = 1'b1; w_addr = 3'd7; w_data = 16'h5A5A; r0_addr = 3'd7; r1_addr = 3'd7;
    push("dual_r0_bypass", 64'h5A5A); push("dual_r1_bypass", 64'h5A5A);
    @(negedge clk);
    pop_chk(64'(r0_data)); pop_chk(64'(r1_data));
    next_cycle();
    w_en = 1'b0; r0_addr = 3'd3; r1_addr = 3'd7;
    push("dual_r0_e3", 64'h1234); push("dual_r1_e7", 64'h5A5A);
    @(negedge clk);
    pop_chk(64'(r0_data)); pop_chk(64'(r1_data));

    // Reserve entry 2 twice: error after the second edge, sticky.
    next_cycle();
    rsv_en = 1'b1; rsv_addr = 3'd2;
    next_cycle();
    push("dup2_err_pre", 64'h0); push("dup2_busy_pre", 64'h14);
    @(negedge clk);
    pop_chk(64'(err)); pop_chk(64'(busy));
    next_cycle();
    rsv_en = 1'b0;
    push("dup2_err", 64'h1); push("dup2_busy", 64'h14);
    @(negedge clk);
    pop_chk(64'(err)); pop_chk(64'(busy));
    next_cycle();
    push("dup2_err_sticky", 64'h1);
    @(negedge clk);
    pop_chk(64'(err));

    // Async reset mid-cycle discards reservations and blocks the live write.
    next_cycle();
    rsv_en = 1'b1; rsv_addr = 3'd6;
    next_cycle();
    rsv_en = 1'b0; r0_addr = 3'd3; r1_addr = 3'd6;
    push("mid_busy", 64'h54); push("mid_r1_busy", 64'h1);
    @(negedge clk);
    pop_chk(64'(busy)); pop_chk(64'(r1_busy));
    #1;
    rst = 1'b1; w_en = 1'b1; w_addr = 3'd3; w_data = 16'h9999;
    #1;
    push("arst_r0_data", 64'h0); push("arst_busy", 64'h0); push("arst_err", 64'h0); push("arst_r1_busy", 64'h0);
    pop_chk(64'(r0_data)); pop_chk(64'(busy)); pop_chk(64'(err)); pop_chk(64'(r1_busy));
    next_cycle();
    rst = 1'b0; w_en = 1'b0; r1_addr = 3'd7;
    push("post_rst_e3", 64'h0); push("post_rst_e7", 64'h0); push("post_rst_busy", 64'h0);
    @(negedge clk);
    pop_chk(64'(r0_data)); pop_chk(64'(r1_data)); pop_chk(64'(busy));

    // Six-entry bank: out-of-range write is dropped and flagged.
    next_cycle();
    b_rst = 1'b0; b_w_en = 1'b1; b_w_addr = 3'd1; b_w_data = 16'h1111;
    next_cycle();
    b_w_addr = 3'd7; b_w_data = 16'h7777; b_r0_addr = 3'd7; b_r1_addr = 3'd1;
    push("b_oor_no_bypass", 64'h0); push("b_oor_r0_busy", 64'h0); push("b_err_pre", 64'h0);
    @(negedge clk);
    pop_chk(64'(b_r0_data)); pop_chk(64'(b_r0_busy)); pop_chk(64'(b_err));
    next_cycle();
    b_w_en = 1'b0;
    push("b_oor_err", 64'h1); push("b_oor_busy", 64'h0); push("b_oor_r0", 64'h0); push("b_e1_kept", 64'h1111);
    @(negedge clk);
    pop_chk(64'(b_err)); pop_chk(64'(b_busy)); pop_chk(64'(b_r0_data)); pop_chk(64'(b_r1_data));
    #1;
    b_rst = 1'b1;
    #1;
    push("b_arst_r1_data", 64'h0); push("b_arst_err", 64'h0); push("b_arst_busy", 64'h0);
    pop_chk(64'(b_r1_data)); pop_chk(64'(b_err)); pop_chk(64'(b_busy));
    next_cycle();
    b_rst = 1'b0; b_rsv_en = 1'b1; b_rsv_addr = 3'd6; b_r0_addr = 3'd6;
    next_cycle();
    b_rsv_en = 1'b0;
    push("b_rsv_oor_err", 64'h1); push("b_rsv_oor_busy", 64'h0); push("b_rsv_oor_r0_busy", 64'h0);
    @(negedge clk);
    pop_chk(64'(b_err)); pop_chk(64'(b_busy)); pop_chk(64'(b_r0_busy));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
